// File: rtl/sync_filter.sv
// sync_filter: per-channel multi-flop synchronizer followed by a runtime
// programmable glitch filter. A channel's output level only changes after the
// synchronized input has disagreed with it for more than filt_len consecutive
// enabled cycles. Every committed change produces a registered one-cycle
// rise/fall pulse.
module sync_filter #(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter int unsigned      FILT_BITS   = 4,
  parameter logic [WIDTH-1:0] RESET_VAL   = {WIDTH{1'b0}}
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     datain,
  input  logic [FILT_BITS-1:0] filt_len,
  input  logic                 enable,
  output logic [WIDTH-1:0]     dataout,
  output logic [WIDTH-1:0]     rise,
  output logic [WIDTH-1:0]     fall,
  output logic                 changed
);

  // Synchronizer chain: index 0 samples datain, the last stage feeds the filter.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]                  s;

  // Filter state per channel.
  logic [WIDTH-1:0][FILT_BITS-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]                  dataout_q, dataout_d;
  logic [WIDTH-1:0]                  rise_q, rise_d;
  logic [WIDTH-1:0]                  fall_q, fall_d;
  logic                              changed_q, changed_d;

  assign s = sync_q[SYNC_STAGES-1];

  // Shift every channel one stage further down the synchronizer.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], datain};
  end

  // Glitch filter: count disagreeing samples, commit once the count reaches
  // filt_len. Using >= lets a lowered filt_len commit a long-running count on
  // the very next edge, and the count can never pass filt_len's maximum value.
  always_comb begin
    cnt_d     = cnt_q;
    dataout_d = dataout_q;
    rise_d    = '0;
    fall_d    = '0;
    if (enable) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (s[i] == dataout_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] < filt_len) begin
          cnt_d[i] = cnt_q[i] + FILT_BITS'(1);
        end else begin
          cnt_d[i]     = '0;
          dataout_d[i] = s[i];
          rise_d[i]    = s[i];
          fall_d[i]    = ~s[i];
        end
      end
    end
    changed_d = |(rise_d | fall_d);
  end

  // State registers with synchronous reset that overrides enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= {SYNC_STAGES{RESET_VAL}};
      cnt_q     <= '0;
      dataout_q <= RESET_VAL;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      dataout_q <= dataout_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  assign dataout = dataout_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_sync_filter.sv
// tb_sync_filter: directed scenarios plus randomized traffic for sync_filter,
// checked every cycle against a behavioural model (delay-line synchronizer and
// a per-channel streak of disagreeing samples).
module tb_sync_filter;

  localparam int unsigned W  = 4;
  localparam int unsigned SS = 2;
  localparam int unsigned FB = 4;

  logic          clk;
  logic          reset;
  logic [W-1:0]  datain;
  logic [FB-1:0] filt_len;
  logic          enable;
  logic [W-1:0]  dataout, rise, fall;
  logic          changed;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  logic [W-1:0] m_pipe[$];
  int           m_streak[W];
  logic [W-1:0] m_out, m_rise, m_fall;
  logic         m_chg;
  bit           m_valid = 0;

  sync_filter #(
    .WIDTH      (W),
    .SYNC_STAGES(SS),
    .FILT_BITS  (FB),
    .RESET_VAL  (4'h0)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .datain  (datain),
    .filt_len(filt_len),
    .enable  (enable),
    .dataout (dataout),
    .rise    (rise),
    .fall    (fall),
    .changed (changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    logic [W-1:0] s;
    if (reset) begin
      m_pipe = {};
      for (int k = 0; k < SS; k++) m_pipe.push_back('0);
      m_out = '0; m_rise = '0; m_fall = '0; m_chg = 1'b0;
      for (int i = 0; i < W; i++) m_streak[i] = 0;
      m_valid = 1;
    end else if (m_valid) begin
      s = m_pipe[SS-1];
      m_pipe.push_front(datain);
      void'(m_pipe.pop_back());
      m_rise = '0; m_fall = '0;
      if (enable) begin
        for (int i = 0; i < W; i++) begin
          if (s[i] == m_out[i]) m_streak[i] = 0;
          else if (m_streak[i] >= int'(filt_len)) begin
            m_out[i] = s[i];
            m_streak[i] = 0;
            if (s[i]) m_rise[i] = 1'b1; else m_fall[i] = 1'b1;
          end else m_streak[i] = m_streak[i] + 1;
        end
      end
      m_chg = (m_rise != 0) || (m_fall != 0);
    end
  endtask

  // One clock: edge, model update, sample 1ns later and compare.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (m_valid) begin
      chk("dataout", 32'(dataout), 32'(m_out));
      chk("rise", 32'(rise), 32'(m_rise));
      chk("fall", 32'(fall), 32'(m_fall));
      chk("changed", 32'(changed), 32'(m_chg));
      chk("rise_and_fall", 32'(rise & fall), 32'd0);
      for (int i = 0; i < W; i++) chk("cnt", 32'(dut.cnt_q[i]), 32'(m_streak[i]));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; datain = '0; filt_len = '0; enable = 1'b1;
    #2;

    // Reset state.
    do_reset();
    chk("reset_dataout", 32'(dataout), 32'd0);
    chk("reset_changed", 32'(changed), 32'd0);

    // filt_len=0: commit after exactly 3 edges, single-cycle pulse.
    filt_len = 4'd0; datain = 4'b0001;
    step(); step();
    chk("f0_pre_dataout", 32'(dataout), 32'd0);
    step();
    chk("f0_dataout", 32'(dataout), 32'h1);
    chk("f0_rise", 32'(rise), 32'h1);
    chk("f0_changed", 32'(changed), 32'd1);
    step();
    chk("f0_rise_gone", 32'(rise), 32'd0);
    chk("f0_changed_gone", 32'(changed), 32'd0);

    // filt_len=3: 3-cycle glitch rejected, 4-cycle level accepted.
    filt_len = 4'd3; datain = 4'b0011;
    step(); step(); step();
    datain = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("glitch_dataout", 32'(dataout), 32'h1);
      chk("glitch_rise", 32'(rise), 32'd0);
    end
    datain = 4'b0011;
    step(); step(); step(); step();
    datain = 4'b0001;
    step();
    chk("f3_pre_dataout", 32'(dataout), 32'h1);
    step();
    chk("f3_dataout", 32'(dataout), 32'h3);
    chk("f3_rise", 32'(rise), 32'h2);
    step(); step(); step();
    chk("f3_pre_fall", 32'(fall), 32'd0);
    step();
    chk("f3_fall", 32'(fall), 32'h2);
    chk("f3_fall_dataout", 32'(dataout), 32'h1);

    // filt_len lowered below a running count commits on the next edge.
    filt_len = 4'd8; datain = 4'b0111;
    for (int k = 0; k < 7; k++) step();
    chk("shrink_cnt2", 32'(dut.cnt_q[2]), 32'd5);
    chk("shrink_pre_dataout", 32'(dataout), 32'h1);
    filt_len = 4'd2;
    step();
    chk("shrink_dataout", 32'(dataout), 32'h7);
    chk("shrink_rise", 32'(rise), 32'h6);

    // enable=0 freezes the filter while the synchronizer keeps running.
    do_reset();
    enable = 1'b0; datain = 4'hF; filt_len = 4'd2;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("frozen_dataout", 32'(dataout), 32'd0);
      chk("frozen_changed", 32'(changed), 32'd0);
    end
    enable = 1'b1;
    step(); step();
    chk("en_pre_rise", 32'(rise), 32'd0);
    step();
    chk("en_rise", 32'(rise), 32'hF);
    chk("en_dataout", 32'(dataout), 32'hF);

    // Reset mid-count, then a reset pulse that misses every edge.
    do_reset();
    filt_len = 4'd5; datain = 4'b0001;
    step(); step(); step(); step();
    chk("mid_cnt0", 32'(dut.cnt_q[0]), 32'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_reset_dataout", 32'(dataout), 32'd0);
    chk("mid_reset_cnt0", 32'(dut.cnt_q[0]), 32'd0);
    chk("mid_reset_changed", 32'(changed), 32'd0);
    reset = 1'b1; #2; reset = 1'b0;
    chk("glitch_reset_sync", 32'(dut.sync_q[0]), 32'd0);
    step();
    chk("after_glitch_sync", 32'(dut.sync_q[0]), 32'h1);

    // Two channels commit on the same edge.
    do_reset();
    filt_len = 4'd1; datain = 4'b1001;
    step(); step(); step();
    chk("dual_pre_rise", 32'(rise), 32'd0);
    step();
    chk("dual_rise", 32'(rise), 32'h9);
    chk("dual_changed", 32'(changed), 32'd1);
    step();
    chk("dual_changed_gone", 32'(changed), 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) datain = W'($urandom);
      if ($urandom_range(0, 15) == 0) filt_len = FB'($urandom_range(0, 5));
      if ($urandom_range(0, 40) == 0) filt_len = 4'hF;
      enable = ($urandom_range(0, 9) != 0);
      reset  = ($urandom_range(0, 150) == 0);
      step();
    end
    reset = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sync_filter.md
SYNC_FILTER -- requirements
Module: sync_filter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of independent input channels (>=1).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer flop depth per channel (>=2).
REQ-003 SHALL have parameter FILT_BITS, default 4, width of the per-channel filter counter and of filt_len.
REQ-004 SHALL have parameter RESET_VAL, default {WIDTH{1'b0}}, reset value of the synchronizer chain and dataout.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port datain  input  WIDTH  asynchronous channel inputs.
REQ-008 SHALL have port filt_len  input  FILT_BITS  runtime glitch-filter threshold; 0 = no filtering.
REQ-009 SHALL have port enable  input  1  1 = filter runs; 0 = filter state frozen.
REQ-010 SHALL have port dataout  output  WIDTH  synchronized, filtered channel levels.
REQ-011 SHALL have port rise  output  WIDTH  one-cycle pulse per channel on a dataout 0->1 transition.
REQ-012 SHALL have port fall  output  WIDTH  one-cycle pulse per channel on a dataout 1->0 transition.
REQ-013 SHALL have port changed  output  1  OR-reduction of (rise | fall), registered alongside them.

Function
REQ-014 SHALL pass each datain bit through SYNC_STAGES flops; last stage is the channel's sampled value s[i].
REQ-015 SHALL keep one FILT_BITS-wide counter cnt[i] per channel; channels fully independent.
REQ-016 SHALL, when enable=1 and s[i]==dataout[i], set cnt[i] to 0 and hold dataout[i].
REQ-017 SHALL, when enable=1, s[i]!=dataout[i] and cnt[i] < filt_len, increment cnt[i] and hold dataout[i].
REQ-018 SHALL, when enable=1, s[i]!=dataout[i] and cnt[i] >= filt_len, set dataout[i]=s[i], cnt[i]=0 and pulse rise[i] or fall[i] that same edge.
REQ-019 SHALL use >= comparison so a filt_len decrease below a running cnt[i] commits on the next edge; cnt[i] never exceeds 2^FILT_BITS-1.
REQ-020 SHALL give a datain-to-dataout latency of exactly SYNC_STAGES + filt_len + 1 clocks for a level held stable throughout.
REQ-021 SHALL discard any s[i] excursion that returns to dataout[i] before the commit condition of REQ-018 (cnt cleared, no pulse).
REQ-022 SHALL, when enable=0, keep the synchronizer running but hold cnt, dataout; rise, fall, changed are 0.
REQ-023 SHALL drive rise, fall, changed as registered outputs, high for exactly one cycle per commit.
REQ-024 SHALL allow any subset of channels to commit on the same edge; each gets its own pulse, changed=1 once.
REQ-025 SHALL never assert rise[i] and fall[i] together.

Reset
REQ-026 SHALL, on any rising clk edge with reset=1, load all synchronizer stages and dataout with RESET_VAL, clear all cnt, rise, fall, changed.
REQ-027 SHALL have reset override enable and any in-progress count; no pulse is emitted on the reset edge.
REQ-028 SHALL, after reset release, treat a datain differing from RESET_VAL as a normal transition (pulse after REQ-020 latency).
REQ-029 SHALL not change state when reset asserts between clock edges (synchronous only).

Verification (WIDTH=4, SYNC_STAGES=2, FILT_BITS=4, RESET_VAL=0)
REQ-030 SHALL verify: filt_len=0, datain[0] 0->1 before edge 1 -> dataout[0]=1 after edge 3, rise=4'b0001 and changed=1 for that one cycle only.
REQ-031 SHALL verify: filt_len=3, datain[1] high 3 cycles -> no dataout/rise/fall change; high 4 cycles -> dataout[1]=1 after edge 6 with rise[1], then fall[1] 6 edges after datain falls.
REQ-032 SHALL verify: filt_len=8, datain[2] held high until cnt[2]=5, then filt_len=2 -> dataout[2]=1 and rise[2] on the next edge.
REQ-033 SHALL verify: enable=0 with datain=4'hF for 20 cycles -> dataout stays 0, no pulses; enable=1 -> rise=4'hF after filt_len+1 edges.
REQ-034 SHALL verify: reset=1 for one edge while cnt[0]=2 -> dataout=0, cnt=0, rise/fall/changed=0; no state change if reset pulses between edges.
REQ-035 SHALL verify: datain bits 0 and 3 toggle same cycle, filt_len=1 -> rise=4'b1001 on one edge, changed=1 single cycle.
